// File: rtl/mem_resp_tracker.sv
// mem_resp_tracker
//   Data-response tracker for the MEM stage. Counts outstanding data-bus
//   requests, discards responses made stale by a pipeline flush (any number
//   of them, via a drop counter) and buffers live read data in arrival order
//   while writeback stalls.
//
// Ports
//   clk, reset    : clock, asynchronous active-high reset
//   req_fire      : data request accepted by the bus this cycle
//   can_issue     : a new request may fire this cycle
//   resp_ok       : data bus returns a response (data_ok)
//   resp_data     : response data (rdata)
//   flush         : pipeline flush; all in-flight and buffered responses go stale
//   out_valid     : head response available to the MEM stage
//   out_data      : head response data
//   out_ready     : MEM stage consumes the head this cycle
//   live_cnt      : non-stale requests in flight
//   drop_cnt      : stale responses still to be discarded
//   protocol_err  : sticky; illegal req_fire or spurious resp_ok seen
//
// Handshake: the head moves to the MEM stage on a cycle where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and out_data is
// stable while out_valid is held without out_ready.
module mem_resp_tracker #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter bit BYPASS          = 1'b1,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_fire,
    output logic                  can_issue,
    input  logic                  resp_ok,
    input  logic [DATA_WIDTH-1:0] resp_data,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      live_cnt,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic                  protocol_err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SUM_W = CNT_W + 2;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    logic [DATA_WIDTH-1:0] mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      fifo_cnt;

    logic [SUM_W-1:0]      occupancy;
    logic                  legal_fire;
    logic                  illegal_fire;
    logic                  stale_resp;
    logic                  live_resp;
    logic                  spurious_resp;
    logic                  resp_taken;
    logic                  fifo_empty;
    logic                  bypass_active;
    logic                  push;
    logic                  pop;

    logic [CNT_W-1:0]      live_cnt_next;
    logic [CNT_W-1:0]      drop_cnt_next;
    logic [CNT_W-1:0]      fifo_cnt_next;

    // Every live request holds a FIFO slot in reserve, so the FIFO can never
    // overflow as long as requests only fire while can_issue is high.
    assign occupancy = SUM_W'(live_cnt) + SUM_W'(drop_cnt) + SUM_W'(fifo_cnt);
    assign can_issue = occupancy < SUM_W'(MAX_OUTSTANDING);

    assign legal_fire   = req_fire && can_issue;
    assign illegal_fire = req_fire && !can_issue;

    // Stale responses are always ahead of live ones in the bus order, so the
    // drop counter is drained first.
    assign stale_resp    = resp_ok && (drop_cnt != '0);
    assign live_resp     = resp_ok && (drop_cnt == '0) && (live_cnt != '0);
    assign spurious_resp = resp_ok && (drop_cnt == '0) && (live_cnt == '0);
    assign resp_taken    = stale_resp || live_resp;

    assign fifo_empty    = (fifo_cnt == '0);
    assign bypass_active = BYPASS && fifo_empty && live_resp && !flush;

    // A bypassed response that is consumed on the spot never touches the FIFO.
    assign push = live_resp && !flush && !(bypass_active && out_ready);
    assign pop  = !flush && !fifo_empty && out_ready;

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        if (!flush) begin
            if (!fifo_empty) begin
                out_valid = 1'b1;
                out_data  = mem[rd_ptr];
            end else if (bypass_active) begin
                out_valid = 1'b1;
                out_data  = resp_data;
            end
        end
    end

    always_comb begin
        live_cnt_next = live_cnt;
        drop_cnt_next = drop_cnt;
        fifo_cnt_next = fifo_cnt;
        if (flush) begin
            // Everything still owed by the bus becomes stale, including a
            // request accepted in this very cycle.
            drop_cnt_next = drop_cnt + live_cnt + CNT_W'(legal_fire) - CNT_W'(resp_taken);
            live_cnt_next = '0;
            fifo_cnt_next = '0;
        end else begin
            live_cnt_next = live_cnt + CNT_W'(legal_fire) - CNT_W'(live_resp);
            drop_cnt_next = drop_cnt - CNT_W'(stale_resp);
            fifo_cnt_next = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_cnt     <= '0;
            drop_cnt     <= '0;
            fifo_cnt     <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            protocol_err <= 1'b0;
        end else begin
            live_cnt <= live_cnt_next;
            drop_cnt <= drop_cnt_next;
            fifo_cnt <= fifo_cnt_next;
            if (illegal_fire || spurious_resp) begin
                protocol_err <= 1'b1;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= resp_data;
        end
    end

endmodule

// File: doc/mem_resp_tracker.md
Name: mem_resp_tracker

Overview:
- Parametrised data-response tracker for the MEM stage.
- Counts outstanding data-bus requests and buffers returned read data in order when writeback stalls.
- Generalises the single-request cancel flag into a drop counter, so any number of in-flight responses (up to the limit) are discarded after a pipeline flush.
- Sits between the data-bus response channel (data_ok/rdata) and the MEM stage ready/valid logic.

Parameters:
DATA_WIDTH, 32, width of returned read data.
MAX_OUTSTANDING, 4, maximum requests in flight plus buffered responses (≥1); also the FIFO depth.
BYPASS, 1, 1 = a response arriving into an empty FIFO is presented combinationally in the same cycle; 0 = always registered (1-cycle latency).
CNT_W, $clog2(MAX_OUTSTANDING+1), counter width (derived; do not override).

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
req_fire  in  1  data request accepted by bus this cycle.
can_issue  out  1  a new request may fire this cycle.
resp_ok  in  1  data bus returns a response (data_ok).
resp_data  in  DATA_WIDTH  response data (rdata).
flush  in  1  pipeline flush; all in-flight and buffered responses become stale.
out_valid  out  1  head response available to MEM stage.
out_data  out  DATA_WIDTH  head response data.
out_ready  in  1  MEM stage consumes head this cycle.
live_cnt  out  CNT_W  non-stale requests in flight.
drop_cnt  out  CNT_W  stale responses still to be discarded.
protocol_err  out  1  sticky: illegal req_fire or spurious resp_ok seen.

Behaviour:
- Reset (async): live_cnt=0, drop_cnt=0, FIFO empty (rd/wr ptr=0, fifo_cnt=0), protocol_err=0. Consequently out_valid=0, out_data=0 and can_issue=1.
- can_issue = (live_cnt + drop_cnt + fifo_cnt) < MAX_OUTSTANDING. This reserves a FIFO slot per live request, so the FIFO cannot overflow.
- req_fire with can_issue=0:
  - ignored (no count change);
  - sets protocol_err.
- Response classification, evaluated on resp_ok each cycle:
  - if drop_cnt>0: stale. Discard and decrement drop_cnt.
  - else if live_cnt>0: live. Decrement live_cnt and write to FIFO (or bypass).
  - else: spurious. Ignore and set protocol_err.
- Counter updates on a non-flush cycle:
  - live_cnt_next = live_cnt + req_fire(legal) − live_resp;
  - drop_cnt_next = drop_cnt − stale_resp.
- Flush cycle:
  - drop_cnt_next = drop_cnt + live_cnt + req_fire(legal) − resp_ok(non-spurious);
  - live_cnt_next = 0;
  - FIFO cleared (ptrs, fifo_cnt=0);
  - a response arriving in the flush cycle is discarded, never written or presented;
  - out_valid is forced 0 in the flush cycle.
- FIFO: circular, MAX_OUTSTANDING entries, pointers wrap modulo depth.
  - Write on live_resp unless bypassed.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop keeps fifo_cnt unchanged.
- Output:
  - out_valid = fifo_cnt>0, or (BYPASS && fifo_cnt==0 && live_resp && !flush).
  - out_data = FIFO head, or resp_data on bypass.
  - Bypass consumed (out_ready=1): nothing is written.
  - Bypass not consumed: the response is written to the FIFO.
  - out_data holds its value while out_valid && !out_ready.
- Order: responses delivered strictly in arrival order.
- protocol_err is cleared only by reset.

Test Plan:
- Reset mid-operation: live_cnt=2, fifo_cnt=1, assert reset asynchronously between edges → all counters 0, out_valid=0, can_issue=1 immediately.
- Back-to-back, BYPASS=1:
  - stimulus: 4 req_fire, then resp_ok with data 0xA0..0xA3, out_ready=1;
  - response: out_valid in the same cycles, data in order, can_issue=0 after the 4th fire.
- Stall buffering:
  - stimulus: out_ready=0, 3 responses 0x11,0x22,0x33;
  - response: fifo_cnt=3, can_issue=1 only with live_cnt=0 (3+0<4);
  - then release out_ready: outputs 0x11,0x22,0x33 on consecutive cycles.
- Flush with in-flight requests:
  - stimulus: live_cnt=3, flush together with req_fire → drop_cnt=4, live_cnt=0, FIFO empty;
  - next 4 resp_ok are discarded (out_valid stays 0);
  - the 5th response after a new fire is delivered.
- Flush coinciding with resp_ok:
  - stimulus: live_cnt=2 → drop_cnt=1;
  - response: the coincident data is never visible.
- Protocol errors:
  - stimulus: req_fire while can_issue=0, or resp_ok with live_cnt=drop_cnt=0;
  - response: protocol_err=1 and sticky, counters unchanged.
